counter_mod_n: RTL



---
 rtl/counter_pkg.sv | 30 +++
 rtl/counter_prescaler.sv | 43 ++++
 rtl/counter_mod_n.sv | 105 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared helpers for the modulo-N counter: prescaler width sizing and
// elaboration-time legality checks for MODULUS and PRESCALE.
package counter_pkg;

  localparam longint unsigned PRESCALE_MAX = 64'd65536;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input longint unsigned value);
    int               r;
    longint unsigned  v;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // 2 <= modulus <= 2^width
  function automatic bit modulus_legal(input int width, input longint modulus);
    return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
  endfunction

  // 1 <= prescale <= 65536
  function automatic bit prescale_legal(input longint prescale);
    return (prescale >= 1) && (longint'(prescale) <= longint'(PRESCALE_MAX));
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Divides the enable stream by PRESCALE: step pulses on every PRESCALE-th
// enabled cycle. sync_clr restarts the division. PRESCALE=1 is pure wiring.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic step
);

  generate
    if (PRESCALE == 1) begin : g_bypass
      // No state; clk/rst are consumed only to keep the port list uniform.
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign step     = en & ~sync_clr;
    end else begin : g_div
      localparam int              PW   = clog2(longint'(PRESCALE));
      localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] r_cnt;

      assign step = en & ~sync_clr & (r_cnt == LAST);

      // Enabled-cycle counter; holds while en=0, restarts on clear or terminal count.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
        end else if (sync_clr) begin
          r_cnt <= '0;
        end else if (en) begin
          if (r_cnt == LAST) r_cnt <= '0;
          else               r_cnt <= r_cnt + PW'(1);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/counter_mod_n.sv
// Up/down modulo-MODULUS counter with enable, synchronous clear, clamped
// parallel load, optional prescaler, registered wrap pulse and a
// combinational at-limit flag.
// Optional feature macro: COUNTER_MOD_N_SATURATE_EN -- boundary steps hold
// the count instead of wrapping, and wrap stays 0.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_limit
);

  generate
    if (!modulus_legal(WIDTH, longint'(MODULUS))) begin : g_bad_modulus
      $error("counter_mod_n: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (!prescale_legal(longint'(PRESCALE))) begin : g_bad_prescale
      $error("counter_mod_n: PRESCALE must satisfy 1 <= PRESCALE <= 65536");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_step;

  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (clr | load),
    .step     (w_step)
  );

  assign w_load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

  // Next count and wrap: clr beats load beats step; wrap only on a boundary step.
  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    if (clr) begin
      w_count_nxt = '0;
    end else if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (w_step) begin
      if (up) begin
        if (r_count == MAX_CNT) begin
`ifdef COUNTER_MOD_N_SATURATE_EN
          w_count_nxt = MAX_CNT;
`else
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
`endif
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end else begin
        if (r_count == '0) begin
`ifdef COUNTER_MOD_N_SATURATE_EN
          w_count_nxt = '0;
`else
          w_count_nxt = MAX_CNT;
          w_wrap_nxt  = 1'b1;
`endif
        end else begin
          w_count_nxt = r_count - WIDTH'(1);
        end
      end
    end
  end

  // Count and wrap registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign at_limit = up ? (r_count == MAX_CNT) : (r_count == '0);

endmodule
